// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, full/empty flags and occupancy count.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic                     read_en,
  input  logic [width-1:0]         datain,
  output logic [width-1:0]         dataout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   countout
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] depth_count = (aw+1)'(depth);

  logic [width-1:0] mem [depth];

  logic [aw-1:0]    wptr_reg, wptr_next;
  logic [aw-1:0]    rptr_reg, rptr_next;
  logic [aw:0]      count_reg, count_next;
  logic [width-1:0] dataout_reg;

  logic do_write;
  logic do_read;

  assign full     = (count_reg == depth_count);
  assign empty    = (count_reg == '0);
  assign countout = count_reg;
  assign dataout  = dataout_reg;

  // A write while full still goes ahead when a read frees the slot on the same edge.
  assign do_read  = read_en && !empty;
  assign do_write = write_en && (!full || do_read);

  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    if (do_write) wptr_next = wptr_reg + aw'(1);
    if (do_read)  rptr_next = rptr_reg + aw'(1);
    case ({do_write, do_read})
      2'b10:   count_next = count_reg + (aw+1)'(1);
      2'b01:   count_next = count_reg - (aw+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage is left uninitialised so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_write) mem[wptr_reg] <= datain;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      count_reg   <= '0;
      dataout_reg <= '0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      if (do_read) dataout_reg <= mem[rptr_reg];
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (write_en && full) overflow_reg  <= 1'b1;
      if (read_en && empty) underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int width = 8;
  localparam int depth = 16;

  logic                   clk;
  logic                   reset;
  logic                   write_en;
  logic                   read_en;
  logic [width-1:0]       datain;
  logic [width-1:0]       dataout;
  logic                   full;
  logic                   empty;
  logic [$clog2(depth):0] countout;
`ifdef FIFO_ERR_FLAGS_EN
  logic                   overflow;
  logic                   underflow;
`endif

  sync_fifo #(.width(width), .depth(depth)) dut (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .read_en  (read_en),
    .datain   (datain),
    .dataout  (dataout),
    .full     (full),
    .empty    (empty),
    .countout (countout)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents as a queue, plus expected output register and sticky flags.
  logic [width-1:0] model_q[$];
  logic [width-1:0] exp_dout;
  logic             exp_ovf;
  logic             exp_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock transaction: drive at negedge, update model, sample 1 time unit after the edge.
  task automatic do_cycle(input logic rst_n, input logic we, input logic re, input logic [width-1:0] din);
    bit m_full, m_empty, m_rd, m_wr;
    @(negedge clk);
    reset    = rst_n;
    write_en = we;
    read_en  = re;
    datain   = din;
    m_full  = (model_q.size() == depth);
    m_empty = (model_q.size() == 0);
    if (!rst_n) begin
      model_q.delete();
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
    end else begin
      m_rd = re && !m_empty;
      m_wr = we && (!m_full || m_rd);
      if (we && m_full)  exp_ovf = 1'b1;
      if (re && m_empty) exp_unf = 1'b1;
      if (m_rd) exp_dout = model_q.pop_front();
      if (m_wr) model_q.push_back(din);
    end
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b we=%0b re=%0b din=%0h -> dout=%0h cnt=%0d full=%0b empty=%0b",
             $time, rst_n, we, re, din, dataout, countout, full, empty);
    check("dataout", 32'(dataout), 32'(exp_dout));
    check("countout", 32'(countout), 32'(model_q.size()));
    check("full", 32'(full), 32'(model_q.size() == depth));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
`endif
  endtask

  initial begin
    reset    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    datain   = '0;
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;

    // Reset state
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    do_cycle(1'b0, 1'b1, 1'b1, 8'hff);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout", 32'(dataout), 32'd0);

    // Single write then single read
    do_cycle(1'b1, 1'b1, 1'b0, 8'd32);
    check("one_cnt", 32'(countout), 32'd1);
    do_cycle(1'b1, 1'b0, 1'b1, 8'd0);
    check("one_dout", 32'(dataout), 32'd32);
    check("one_empty", 32'(empty), 32'd1);

    // Fill with 0..15, then drain in order
    for (int i = 0; i < depth; i++) do_cycle(1'b1, 1'b1, 1'b0, 8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_cnt", 32'(countout), 32'd16);
    for (int i = 0; i < depth; i++) do_cycle(1'b1, 1'b0, 1'b1, 8'd0);
    check("drain_last", 32'(dataout), 32'd15);

    // Overflow: 18 writes, last two dropped
    for (int i = 0; i < depth + 2; i++) do_cycle(1'b1, 1'b1, 1'b0, 8'(8'd100 + 8'(i)));
    check("ovf_cnt", 32'(countout), 32'd16);
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf_flag", 32'(overflow), 32'd1);
`endif
    for (int i = 0; i < depth; i++) do_cycle(1'b1, 1'b0, 1'b1, 8'd0);
    check("ovf_last", 32'(dataout), 32'd115);

    // Underflow: dataout holds 22 across a read from empty
    do_cycle(1'b1, 1'b1, 1'b0, 8'd22);
    do_cycle(1'b1, 1'b0, 1'b1, 8'd0);
    do_cycle(1'b1, 1'b0, 1'b1, 8'd0);
    check("unf_dout", 32'(dataout), 32'd22);
    check("unf_cnt", 32'(countout), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("unf_flag", 32'(underflow), 32'd1);
`endif

    // Wrap-around: fill, read 2, write 21, read 15
    for (int i = 0; i < depth; i++) do_cycle(1'b1, 1'b1, 1'b0, 8'(8'd50 + 8'(i)));
    do_cycle(1'b1, 1'b0, 1'b1, 8'd0);
    do_cycle(1'b1, 1'b0, 1'b1, 8'd0);
    do_cycle(1'b1, 1'b1, 1'b0, 8'd21);
    for (int i = 0; i < depth - 1; i++) do_cycle(1'b1, 1'b0, 1'b1, 8'd0);
    check("wrap_dout", 32'(dataout), 32'd21);
    check("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous at count=1, then mid-operation reset
    do_cycle(1'b1, 1'b1, 1'b0, 8'd9);
    do_cycle(1'b1, 1'b1, 1'b1, 8'd31);
    check("sim_cnt", 32'(countout), 32'd1);
    check("sim_dout", 32'(dataout), 32'd9);
    do_cycle(1'b1, 1'b1, 1'b0, 8'd44);
    do_cycle(1'b0, 1'b1, 1'b1, 8'd77);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_cnt", 32'(countout), 32'd0);
    check("mrst_dout", 32'(dataout), 32'd0);

    // Simultaneous while full: read frees the slot for the write
    for (int i = 0; i < depth; i++) do_cycle(1'b1, 1'b1, 1'b0, 8'(8'd200 + 8'(i)));
    do_cycle(1'b1, 1'b1, 1'b1, 8'd5);
    check("fullrw_cnt", 32'(countout), 32'd16);
    check("fullrw_dout", 32'(dataout), 32'd200);

    // Randomised phases: write-heavy, read-heavy, balanced, with occasional reset
    for (int i = 0; i < 3000; i++) begin
      int phase;
      logic we, re, rn;
      phase = (i / 150) % 3;
      case (phase)
        0:       begin we = ($urandom_range(0, 9) < 8); re = ($urandom_range(0, 9) < 2); end
        1:       begin we = ($urandom_range(0, 9) < 2); re = ($urandom_range(0, 9) < 8); end
        default: begin we = 1'($urandom_range(0, 1));   re = 1'($urandom_range(0, 1));   end
      endcase
      rn = ($urandom_range(0, 299) != 0);
      do_cycle(rn, we, re, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO. Parameterised data width and depth.
- Registered read-data output, full/empty flags and an occupancy count.
- Used as a general-purpose rate/ordering buffer between a producer and a consumer in the same clock domain.

Parameters:
- width, 8, data word width in bits.
- depth, 16, number of storage entries; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- write_en  input  1  write request; datain is stored when accepted.
- read_en  input  1  read request; oldest entry is moved to dataout when accepted.
- datain  input  width  write data.
- dataout  output  width  registered read data.
- full  output  1  high when count == depth.
- empty  output  1  high when count == 0.
- countout  output  $clog2(depth)+1  current occupancy, 0..depth.

Behaviour:
- Reset (reset==0 at a rising edge):
  - Write pointer, read pointer and count go to 0.
  - dataout goes to 0; empty=1; full=0.
  - Memory contents need not be cleared.
  - Reset has priority over write_en and read_en in the same cycle.
- Flags and count:
  - full, empty and countout are combinational decodes of the registered count, or registered equivalents.
  - In either case they must reflect the updated count in the cycle after the edge.
- Write acceptance: write_en==1 and full==0 at a rising edge.
  - mem[wptr] <= datain.
  - wptr advances by 1 modulo depth, wrapping depth-1 -> 0.
- Read acceptance: read_en==1 and empty==0 at a rising edge.
  - dataout <= mem[rptr].
  - rptr advances by 1 modulo depth.
  - Read latency is 1 cycle: data is valid on dataout right after the accepting edge.
- dataout holds its last value whenever no read is accepted.
- Count update per edge:
  - Write only: +1.
  - Read only: -1.
  - Both accepted: unchanged.
  - Neither: unchanged.
- Simultaneous write_en and read_en:
  - Not empty and not full: both performed, count unchanged.
  - Empty: only the write is performed; count 0 -> 1; dataout unchanged.
  - Full: both performed, so the read frees a slot for the write; count stays depth.
- Overflow: write_en while full is ignored. Memory, wptr and count are unchanged, and countout never exceeds depth.
- Underflow: read_en while empty is ignored. dataout keeps its previous value (never X after reset); rptr and count are unchanged.
- Ordering: strict first-in first-out across pointer wrap-around.
- Mid-operation reset: all pending state is discarded. empty=1 on the cycle after the reset edge, regardless of prior occupancy.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, the block adds two output ports:
  - overflow  output  1: sticky; set on any edge where write_en==1 and full==1.
  - underflow  output  1: sticky; set on any edge where read_en==1 and empty==1.
  - Both are cleared only by reset.
- When not defined, these ports and their logic do not exist. All other behaviour is identical in both builds.

Test Plan:
- Reset, then write 8'd32 for one cycle, then read one cycle -> after the write empty=0 and countout=1; after the read dataout=8'd32, empty=1, countout=0.
- Write 16 words 0..15 back-to-back, then read 16 times -> full=1 and countout=16 after the 16th write; reads return 0,1,...,15 in order; empty=1 at the end.
- Fill to 16, then write 2 more words (18 writes total) -> countout stays 16 and the extra data is dropped; subsequent reads return the first 16 words; with FIFO_ERR_FLAGS_EN, overflow=1.
- From empty, with dataout holding 8'd22, assert read_en for one cycle -> dataout stays 8'd22 and countout stays 0; with FIFO_ERR_FLAGS_EN, underflow=1.
- Wrap-around: fill 16, read 2, write 8'd21, then read 15 more -> the 15th of those reads (the last one) returns 8'd21 after the pointer wrap; empty=1 at the end.
- Simultaneous and reset cases:
  - With count=1, assert write_en and read_en together with datain=8'd31 -> count stays 1 and dataout is the old head.
  - Then write 8'd44 and pulse reset low for one cycle -> empty=1, countout=0, dataout=0.
